// File: rtl/wb_write_queue_pkg.sv
// -----------------------------------------------------------------------------
// wb_write_queue_pkg
// Shared constants for the register-file writeback path.
//   REGISTER_FILE_ADDRESS_LEN : register address width
//   REGISTER_FILE_LEN         : register data width
//   WB_QUEUE_DEPTH            : default writeback queue depth (power of two, >= 2)
// -----------------------------------------------------------------------------
package wb_write_queue_pkg;

  localparam int REGISTER_FILE_ADDRESS_LEN = 4;
  localparam int REGISTER_FILE_LEN         = 32;
  localparam int WB_QUEUE_DEPTH            = 4;

endpackage

// File: rtl/wb_fifo_mem.sv
// -----------------------------------------------------------------------------
// wb_fifo_mem
// Storage for the writeback queue: DEPTH entries of {dest, value}, each with a
// valid bit. Two write ports (used at wptr and wptr+1 by the parent), one read
// port for the head entry, and a pending-write compare against two hazard query
// addresses.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset (valid bits)
//   we_0/waddr_0/wdest_0/wdata_0   write port 0
//   we_1/waddr_1/wdest_1/wdata_1   write port 1
//   pop, raddr               clear valid bit of the head entry being drained
//   rdest, rdata             head entry contents (combinational)
//   rd_addr_1/2, hit_1/2     pending-write hit flags over valid entries
// -----------------------------------------------------------------------------
module wb_fifo_mem #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we_0,
  input  logic [$clog2(DEPTH)-1:0] waddr_0,
  input  logic [ADDR_W-1:0]        wdest_0,
  input  logic [DATA_W-1:0]        wdata_0,
  input  logic                     we_1,
  input  logic [$clog2(DEPTH)-1:0] waddr_1,
  input  logic [ADDR_W-1:0]        wdest_1,
  input  logic [DATA_W-1:0]        wdata_1,
  input  logic                     pop,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [ADDR_W-1:0]        rdest,
  output logic [DATA_W-1:0]        rdata,
  input  logic [ADDR_W-1:0]        rd_addr_1,
  input  logic [ADDR_W-1:0]        rd_addr_2,
  output logic                     hit_1,
  output logic                     hit_2
);

  logic [ADDR_W-1:0] dest_q [DEPTH];
  logic [ADDR_W-1:0] dest_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic [DEPTH-1:0]  vld_d;

  always_comb begin
    dest_d = dest_q;
    data_d = data_q;
    vld_d  = vld_q;
    // The head slot is never a write target in the same cycle (writes only go
    // to free slots), so clear-then-set ordering is only a safety net.
    if (pop) vld_d[raddr] = 1'b0;
    if (we_0) begin
      dest_d[waddr_0] = wdest_0;
      data_d[waddr_0] = wdata_0;
      vld_d[waddr_0]  = 1'b1;
    end
    if (we_1) begin
      dest_d[waddr_1] = wdest_1;
      data_d[waddr_1] = wdata_1;
      vld_d[waddr_1]  = 1'b1;
    end
  end

  // Payload carries no reset; only the valid bits qualify it.
  always_ff @(posedge clk) begin
    dest_q <= dest_d;
    data_q <= data_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_d;
  end

  assign rdest = dest_q[raddr];
  assign rdata = data_q[raddr];

  always_comb begin
    hit_1 = 1'b0;
    hit_2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (dest_q[i] == rd_addr_1)) hit_1 = 1'b1;
      if (vld_q[i] && (dest_q[i] == rd_addr_2)) hit_2 = 1'b1;
    end
  end

endmodule

// File: rtl/wb_write_queue.sv
// -----------------------------------------------------------------------------
// wb_write_queue
// Write-side producer for the register file's single write port. Accepts
// writeback requests from the MEM load path and the ALU result path, queues
// them in acceptance order (MEM older than ALU when both arrive together) and
// drains one write per cycle onto registered wb_en/wb_dest/wb_value. Pending
// entries are exposed to the hazard unit through hit_1/hit_2.
// Optional build macro: WB_QUEUE_BYPASS_EN -- when the queue is empty, the
// first accepted request goes straight to the wb outputs (latency 1).
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   mem_valid/dest/value, mem_ready   MEM-path request handshake
//   alu_valid/dest/value, alu_ready   ALU-path request handshake
//   wb_en, wb_dest, wb_value          register-file write port (registered)
//   rd_addr_1/2, hit_1/2              hazard query, combinational hit flags
//   count, full, empty                queue occupancy status
// -----------------------------------------------------------------------------
module wb_write_queue
  import wb_write_queue_pkg::*;
#(
  parameter int DEPTH  = WB_QUEUE_DEPTH,
  parameter int ADDR_W = REGISTER_FILE_ADDRESS_LEN,
  parameter int DATA_W = REGISTER_FILE_LEN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_valid,
  input  logic [ADDR_W-1:0]      mem_dest,
  input  logic [DATA_W-1:0]      mem_value,
  output logic                   mem_ready,
  input  logic                   alu_valid,
  input  logic [ADDR_W-1:0]      alu_dest,
  input  logic [DATA_W-1:0]      alu_value,
  output logic                   alu_ready,
  output logic                   wb_en,
  output logic [ADDR_W-1:0]      wb_dest,
  output logic [DATA_W-1:0]      wb_value,
  input  logic [ADDR_W-1:0]      rd_addr_1,
  input  logic [ADDR_W-1:0]      rd_addr_2,
  output logic                   hit_1,
  output logic                   hit_2,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              wb_en_q, wb_en_d;
  logic [ADDR_W-1:0] wb_dest_q, wb_dest_d;
  logic [DATA_W-1:0] wb_value_q, wb_value_d;

  logic [CW-1:0]     free;
  logic              mem_acc, alu_acc;
  logic              byp_mem, byp_alu;
  logic              st_mem, st_alu;
  logic [1:0]        n_store;
  logic              pop;

  logic              we_0, we_1;
  logic [PW-1:0]     waddr_0, waddr_1;
  logic [ADDR_W-1:0] wdest_0;
  logic [DATA_W-1:0] wdata_0;
  logic [ADDR_W-1:0] head_dest;
  logic [DATA_W-1:0] head_value;

  always_comb begin
    // Readiness looks only at registered occupancy; a same-cycle pop earns no
    // credit, which keeps ready off the drain path.
    free      = CW'(DEPTH) - count_q;
    mem_ready = (free != '0);
    alu_ready = (free >= CW'(2)) || ((free == CW'(1)) && !mem_valid);
    mem_acc   = mem_valid && mem_ready;
    alu_acc   = alu_valid && alu_ready;
    pop       = (count_q != '0);

`ifdef WB_QUEUE_BYPASS_EN
    // Empty queue: the oldest accepted request skips storage. pop is 0 here,
    // so the output register is never contended.
    byp_mem = (count_q == '0) && mem_acc;
    byp_alu = (count_q == '0) && alu_acc && !mem_acc;
`else
    byp_mem = 1'b0;
    byp_alu = 1'b0;
`endif

    st_mem  = mem_acc && !byp_mem;
    st_alu  = alu_acc && !byp_alu;
    n_store = {1'b0, st_mem} + {1'b0, st_alu};

    // Port 0 takes the older stored entry at wptr; port 1 is only used when
    // both are stored, for the ALU entry at wptr+1.
    we_0    = st_mem || st_alu;
    waddr_0 = wptr_q;
    wdest_0 = st_mem ? mem_dest  : alu_dest;
    wdata_0 = st_mem ? mem_value : alu_value;
    we_1    = st_mem && st_alu;
    waddr_1 = wptr_q + PW'(1);

    wptr_d  = wptr_q + PW'(n_store);
    rptr_d  = rptr_q + PW'(pop);
    count_d = count_q + CW'(n_store) - CW'(pop);

    wb_en_d    = pop || byp_mem || byp_alu;
    wb_dest_d  = wb_dest_q;
    wb_value_d = wb_value_q;
    if (pop) begin
      wb_dest_d  = head_dest;
      wb_value_d = head_value;
    end else if (byp_mem) begin
      wb_dest_d  = mem_dest;
      wb_value_d = mem_value;
    end else if (byp_alu) begin
      wb_dest_d  = alu_dest;
      wb_value_d = alu_value;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      wb_en_q    <= 1'b0;
      wb_dest_q  <= '0;
      wb_value_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      wb_en_q    <= wb_en_d;
      wb_dest_q  <= wb_dest_d;
      wb_value_q <= wb_value_d;
    end
  end

  wb_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk       (clk),
    .rst       (rst),
    .we_0      (we_0),
    .waddr_0   (waddr_0),
    .wdest_0   (wdest_0),
    .wdata_0   (wdata_0),
    .we_1      (we_1),
    .waddr_1   (waddr_1),
    .wdest_1   (alu_dest),
    .wdata_1   (alu_value),
    .pop       (pop),
    .raddr     (rptr_q),
    .rdest     (head_dest),
    .rdata     (head_value),
    .rd_addr_1 (rd_addr_1),
    .rd_addr_2 (rd_addr_2),
    .hit_1     (hit_1),
    .hit_2     (hit_2)
  );

  assign wb_en    = wb_en_q;
  assign wb_dest  = wb_dest_q;
  assign wb_value = wb_value_q;
  assign count    = count_q;
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);

endmodule

// File: tb/tb_wb_write_queue.sv
// -----------------------------------------------------------------------------
// tb_wb_write_queue
// Scoreboard bench for wb_write_queue. The driver keeps a reference queue of
// stored writes and pushes every accepted request onto a scoreboard; a monitor
// pops and compares whenever wb_en is seen.
// -----------------------------------------------------------------------------
module tb_wb_write_queue;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_dest;
  logic [DATA_W-1:0] mem_value;
  logic              mem_ready;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_dest;
  logic [DATA_W-1:0] alu_value;
  logic              alu_ready;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_dest;
  logic [DATA_W-1:0] wb_value;
  logic [ADDR_W-1:0] rd_addr_1;
  logic [ADDR_W-1:0] rd_addr_2;
  logic              hit_1;
  logic              hit_2;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;

  typedef struct packed {
    logic [ADDR_W-1:0] d;
    logic [DATA_W-1:0] v;
  } wr_t;

  wr_t sb[$];   // every accepted write, in issue order
  wr_t mq[$];   // writes currently held in the queue

  int total = 0;
  int bad   = 0;

  wb_write_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_valid (mem_valid),
    .mem_dest  (mem_dest),
    .mem_value (mem_value),
    .mem_ready (mem_ready),
    .alu_valid (alu_valid),
    .alu_dest  (alu_dest),
    .alu_value (alu_value),
    .alu_ready (alu_ready),
    .wb_en     (wb_en),
    .wb_dest   (wb_dest),
    .wb_value  (wb_value),
    .rd_addr_1 (rd_addr_1),
    .rd_addr_2 (rd_addr_2),
    .hit_1     (hit_1),
    .hit_2     (hit_2),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_hit(input logic [ADDR_W-1:0] a);
    foreach (mq[i]) if (mq[i].d == a) return 1'b1;
    return 1'b0;
  endfunction

  // One clock of stimulus plus the checks derived from the reference queue.
  task automatic cycle(input bit mv, input logic [ADDR_W-1:0] md, input logic [DATA_W-1:0] mval,
                       input bit av, input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] aval,
                       input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2);
    int  free;
    bit  emr, ear, am, aa, issued, was_empty;
    wr_t em, ea;
    @(negedge clk);
    mem_valid = mv; mem_dest = md; mem_value = mval;
    alu_valid = av; alu_dest = ad; alu_value = aval;
    rd_addr_1 = r1; rd_addr_2 = r2;
    #1;
    chk("count", count, mq.size());
    chk("full",  full,  mq.size() == DEPTH);
    chk("empty", empty, mq.size() == 0);
    chk("hit_1", hit_1, model_hit(r1));
    chk("hit_2", hit_2, model_hit(r2));
    free = DEPTH - mq.size();
    emr  = (free >= 1);
    ear  = (free >= 2) || (free == 1 && !mv);
    chk("mem_ready", mem_ready, emr);
    chk("alu_ready", alu_ready, ear);
    am = mv && emr;
    aa = av && ear;
    em.d = md; em.v = mval;
    ea.d = ad; ea.v = aval;
    @(posedge clk);
    was_empty = (mq.size() == 0);
    issued    = !was_empty;
    if (!was_empty) void'(mq.pop_front());
    if (am) sb.push_back(em);
    if (aa) sb.push_back(ea);
`ifdef WB_QUEUE_BYPASS_EN
    if (was_empty && (am || aa)) begin
      issued = 1'b1;
      if (am && aa) mq.push_back(ea);
    end else begin
      if (am) mq.push_back(em);
      if (aa) mq.push_back(ea);
    end
`else
    if (am) mq.push_back(em);
    if (aa) mq.push_back(ea);
`endif
    #1;
    chk("wb_en", wb_en, issued);
  endtask

  task automatic idle(input int n, input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2);
    for (int i = 0; i < n; i++) cycle(0, '0, '0, 0, '0, '0, r1, r2);
  endtask

  // Monitor: every issued write must match the oldest outstanding accepted one.
  always @(negedge clk) begin : mon
    wr_t e;
    if (!rst && wb_en) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wb_extra act dest=%0d value=%0h exp no write", wb_dest, wb_value);
      end else begin
        e = sb.pop_front();
        chk("wb_dest",  wb_dest,  e.d);
        chk("wb_value", wb_value, e.v);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "time limit");
  end

  initial begin : main
    rst = 1'b1;
    mem_valid = 0; mem_dest = '0; mem_value = '0;
    alu_valid = 0; alu_dest = '0; alu_value = '0;
    rd_addr_1 = '0; rd_addr_2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_wb_en", wb_en, 0);
    chk("rst_wb_dest", wb_dest, 0);
    chk("rst_wb_value", wb_value, 0);
    chk("rst_empty", empty, 1);
    chk("rst_hit_1", hit_1, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single ALU write.
    cycle(0, 0, 0, 1, 4'd5, 32'hDEADBEEF, 4'd5, 4'd0);
    idle(3, 4'd5, 4'd0);

    // Simultaneous MEM/ALU to the same register while empty.
    cycle(1, 4'd3, 32'h11, 1, 4'd3, 32'h22, 4'd3, 4'd1);
    idle(4, 4'd3, 4'd1);

    // Back-pressure: both sources valid every cycle.
    for (int i = 0; i < 10; i++)
      cycle(1, 4'(i), 32'h100 + i, 1, 4'(i + 8), 32'h200 + i, 4'(i), 4'(i + 8));
    idle(6, 4'd0, 4'd8);

    // Pointer wrap with a steady ALU stream.
    for (int d = 0; d < 10; d++)
      cycle(0, 0, 0, 1, 4'(d), DATA_W'(d * 3), 4'(d), 4'((d + 15) % 16));
    idle(4, 4'd9, 4'd8);

    // Hazard flags for a single pending write to r7.
    cycle(0, 0, 0, 1, 4'd7, 32'h7777, 4'd8, 4'd7);
    idle(4, 4'd8, 4'd7);

    // Randomized traffic.
    for (int i = 0; i < 300; i++)
      cycle($urandom_range(0, 99) < 60, 4'($urandom), $urandom,
            $urandom_range(0, 99) < 60, 4'($urandom), $urandom,
            4'($urandom), 4'($urandom));
    idle(8, 4'd0, 4'd1);
    chk("drain_sb", sb.size(), 0);

    // Reset mid-operation with entries queued.
    cycle(1, 4'd1, 32'hA1, 1, 4'd2, 32'hA2, 4'd1, 4'd2);
    cycle(1, 4'd3, 32'hA3, 1, 4'd4, 32'hA4, 4'd3, 4'd4);
    cycle(1, 4'd5, 32'hA5, 1, 4'd6, 32'hA6, 4'd5, 4'd6);
    @(negedge clk);
    mem_valid = 0; alu_valid = 0;
    rd_addr_1 = mq.size() > 0 ? mq[0].d : 4'd5;
    rd_addr_2 = mq.size() > 1 ? mq[1].d : 4'd6;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_wb_en", wb_en, 0);
    chk("mid_rst_wb_dest", wb_dest, 0);
    chk("mid_rst_wb_value", wb_value, 0);
    chk("mid_rst_hit_1", hit_1, 0);
    chk("mid_rst_hit_2", hit_2, 0);
    chk("mid_rst_empty", empty, 1);
    sb.delete();
    mq.delete();
    @(posedge clk);
    #1;
    chk("mid_rst_wb_en_hold", wb_en, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(6, 4'd5, 4'd6);
    chk("post_rst_sb", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_write_queue.md
Name: wb_write_queue

Overview:
- Write-side producer for the register file's single write port.
- Accepts register writeback requests from two sources: the ALU/EXE result path and the MEM load path.
- Buffers requests in an in-order FIFO and drains at most one write per cycle onto wb_en/wb_dest/wb_value.
- Exports pending-write hit flags so the hazard unit can stall ID-stage reads of registers whose writes are still queued.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- ADDR_W, `REGISTER_FILE_ADDRESS_LEN (4), register address width.
- DATA_W, `REGISTER_FILE_LEN (32), register data width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- mem_valid  in  1  MEM-path write request.
- mem_dest  in  ADDR_W  MEM-path destination register.
- mem_value  in  DATA_W  MEM-path write data.
- mem_ready  out  1  MEM request accepted this cycle when mem_valid && mem_ready.
- alu_valid  in  1  ALU-path write request.
- alu_dest  in  ADDR_W  ALU-path destination register.
- alu_value  in  DATA_W  ALU-path write data.
- alu_ready  out  1  ALU request accepted this cycle when alu_valid && alu_ready.
- wb_en  out  1  register-file write enable (registered).
- wb_dest  out  ADDR_W  register-file write address (registered).
- wb_value  out  DATA_W  register-file write data (registered).
- rd_addr_1  in  ADDR_W  hazard query address 1.
- rd_addr_2  in  ADDR_W  hazard query address 2.
- hit_1  out  1  queued write pending to rd_addr_1 (combinational).
- hit_2  out  1  queued write pending to rd_addr_2 (combinational).
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - count=0 and read/write pointers=0.
  - wb_en=0, wb_dest=0, wb_value=0.
  - All queued entries are discarded; hit_1/hit_2 drop to 0 immediately.
- Ready generation is based on registered count only; no credit is given for a same-cycle pop.
  - free = DEPTH - count.
  - mem_ready = (free >= 1).
  - alu_ready = (free >= 2) || (free == 1 && !mem_valid).
- Enqueue order when both sources are accepted in one cycle:
  - The MEM entry is written first, at wptr; the ALU entry is written at wptr+1. MEM holds the older instruction.
  - When free==1 and both sources are valid, only MEM is accepted and the ALU request holds.
- Drain:
  - On each posedge with count>0, the head entry pops into wb_en/wb_dest/wb_value, with wb_en=1.
  - On a posedge with count==0, wb_en=0. wb_dest and wb_value hold their previous values.
- Latency: a request accepted at edge N appears on the wb outputs after edge N+1, at the earliest.
- Pointers wrap modulo DEPTH.
- count_next = count + pushes(0..2) - pop(0/1). Push and pop in the same edge are legal at any occupancy, including full (pop only, since ready is low).
- Ordering: writes issue strictly in acceptance order. Two queued writes to the same dest both issue, and the later one wins.
- Hazard flags:
  - hit_n = OR over valid FIFO entries of (dest == rd_addr_n).
  - The output-register stage is excluded, because the register file commits it on the negedge of the same cycle.
  - Requests arriving this cycle are not included.
- r0..r15 are not special-cased; PC handling is outside this block.

Optional Feature:
- Macro: WB_QUEUE_BYPASS_EN.
- Defined:
  - When count==0 and exactly one request is accepted at edge N, it goes directly to the wb outputs at edge N and is not stored, giving latency 1.
  - If both sources are accepted while empty, MEM bypasses and ALU is enqueued.
  - count, hit and ordering rules are unchanged.
- Undefined: every request passes through the FIFO, giving minimum latency 2.

Decomposition:
- Shared constants: REGISTER_FILE_ADDRESS_LEN, REGISTER_FILE_LEN and the new WB_QUEUE_DEPTH go in the existing shared Constants.v include.
- One sub-module, wb_fifo_mem: DEPTH x (ADDR_W+DATA_W) storage, a per-entry valid bit, dual write ports (wptr, wptr+1), one read port, and the dest-compare logic for the hit flags.
- Arbitration, pointers, count and output registers stay in wb_write_queue.

Test Plan:
- Reset mid-operation:
  - Stimulus: fill 3 entries, then assert rst between clock edges.
  - Required: count=0, wb_en=0, wb_dest=0, wb_value=0, hit_1=hit_2=0 immediately, with no write issued afterwards.
- Single ALU write:
  - Stimulus: alu dest=5, value=0xDEADBEEF, accepted at edge N.
  - Required: wb_en=1, wb_dest=5, wb_value=0xDEADBEEF after edge N+1 (after edge N with WB_QUEUE_BYPASS_EN); wb_en=0 the following cycle.
- Simultaneous requests:
  - Stimulus: mem (3, 0x11) and alu (3, 0x22) in the same cycle while empty.
  - Required: two consecutive writes, first 0x11 then 0x22 to r3; hit_1=1 with rd_addr_1=3 while either is queued.
- Full back-pressure:
  - Stimulus: DEPTH=4; hold both sources valid every cycle.
  - Required: mem_ready/alu_ready follow the free-slot rule; count never exceeds 4; at free==1 only MEM is accepted.
- Pointer wrap:
  - Stimulus: 10 ALU writes to dests 0..9 with value=dest*3, at a steady one push per cycle.
  - Required: wb outputs issue in exact order with correct values; pointers wrap with no loss or duplication.
- Hazard flags:
  - Stimulus: queue a write to r7, with rd_addr_2=7 and rd_addr_1=8.
  - Required: hit_2=1 and hit_1=0 until the edge where the r7 entry pops, then hit_2=0.
